// File: rtl/tree_node_pkg.sv
// tree_node_pkg: shared state/mode types and popcount helper for the tree control node
package tree_node_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_e;
  typedef enum logic {MODE_PAR, MODE_SEQ} mode_e;
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c += {5'd0, v[i]};
    return c;
  endfunction
endpackage

// File: rtl/tree_node_next_idx.sv
// tree_node_next_idx: lowest-set-bit finder selecting the next child to launch
module tree_node_next_idx #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_vec,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);
  // scan from the top so the lowest set bit is the last one written
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) if (i_vec[i]) o_idx = IW'(i);
  end
  assign o_valid = |i_vec;
endmodule

// File: rtl/tree_node_seq.sv
// tree_node_seq: launches masked children in parallel or one at a time and reports aggregated done/timeout
module tree_node_seq
  import tree_node_pkg::*;
#(
  parameter int N_CHILD     = 5,
  parameter int TIMEOUT_CYC = 256,
  localparam int CNT_W      = $clog2(N_CHILD + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               mode_i,
  input  logic [N_CHILD-1:0] child_mask_i,
  output logic [N_CHILD-1:0] child_start_o,
  input  logic [N_CHILD-1:0] child_done_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [CNT_W-1:0]   done_cnt_o
);
  localparam int IDX_W = (N_CHILD > 1) ? $clog2(N_CHILD) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC);
  state_e             r_st, w_st_nx;
  mode_e              r_mode, w_mode_nx;
  logic [N_CHILD-1:0] r_mask, w_mask_nx;
  logic [N_CHILD-1:0] r_rem, w_rem_nx;
  logic [N_CHILD-1:0] r_sticky, w_sticky_nx;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic               r_err, w_err_nx;
  logic [TO_W-1:0]    r_to, w_to_nx;
  logic [IDX_W-1:0]   w_idx;
  logic               w_valid;
  logic [N_CHILD-1:0] w_onehot;
  logic               w_fin;
  tree_node_next_idx #(.N(N_CHILD), .IW(IDX_W)) u_next_idx (
    .i_vec  (r_rem),
    .o_idx  (w_idx),
    .o_valid(w_valid)
  );
  assign w_onehot      = N_CHILD'(1) << w_idx;
  assign busy_o        = (r_st == LAUNCH) || (r_st == WAIT);
  assign done_o        = (r_st == DONE);
  assign err_o         = r_err;
  assign done_cnt_o    = r_cnt;
  assign child_start_o = (r_st == LAUNCH) ? ((r_mode == MODE_SEQ) ? w_onehot : r_mask) : '0;
  // next-state and datapath update; completion of a wait takes priority over timeout
  always_comb begin
    w_st_nx     = r_st;
    w_mode_nx   = r_mode;
    w_mask_nx   = r_mask;
    w_rem_nx    = r_rem;
    w_sticky_nx = r_sticky;
    w_cnt_nx    = r_cnt;
    w_err_nx    = r_err;
    w_to_nx     = r_to;
    w_fin       = 1'b0;
    case (r_st)
      IDLE: if (start_i) begin
        w_mode_nx   = mode_e'(mode_i);
        w_mask_nx   = child_mask_i;
        w_rem_nx    = child_mask_i;
        w_sticky_nx = '0;
        w_cnt_nx    = '0;
        w_err_nx    = 1'b0;
        w_st_nx     = (|child_mask_i) ? LAUNCH : DONE;
      end
      LAUNCH: begin
        w_to_nx = '0;
        w_st_nx = WAIT;
      end
      WAIT: begin
        w_to_nx = r_to + 1'b1;
        if (r_mode == MODE_PAR) begin
          w_sticky_nx = r_sticky | (child_done_i & r_mask);
          w_cnt_nx    = CNT_W'(popcount(32'(w_sticky_nx)));
          w_fin       = (w_sticky_nx == r_mask);
          if (w_fin) w_st_nx = DONE;
        end else if (w_valid && child_done_i[w_idx]) begin
          w_fin    = 1'b1;
          w_cnt_nx = r_cnt + 1'b1;
          w_rem_nx = r_rem & ~w_onehot;
          w_st_nx  = (|w_rem_nx) ? LAUNCH : DONE;
        end
        if (!w_fin && r_to == TO_W'(TIMEOUT_CYC - 1)) begin
          w_err_nx = 1'b1;
          w_st_nx  = DONE;
        end
      end
      default: w_st_nx = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st     <= IDLE;
      r_mode   <= MODE_PAR;
      r_mask   <= '0;
      r_rem    <= '0;
      r_sticky <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_to     <= '0;
    end else begin
      r_st     <= w_st_nx;
      r_mode   <= w_mode_nx;
      r_mask   <= w_mask_nx;
      r_rem    <= w_rem_nx;
      r_sticky <= w_sticky_nx;
      r_cnt    <= w_cnt_nx;
      r_err    <= w_err_nx;
      r_to     <= w_to_nx;
    end
  end
endmodule

// File: tb/tb_tree_node_seq.sv
// tb_tree_node_seq: directed checks of launch order, counting, timeout and reset behaviour
module tb_tree_node_seq;
  localparam int N  = 5;
  localparam int TO = 16;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic         mode_i = 1'b0;
  logic [N-1:0] child_mask_i = '0;
  logic [N-1:0] child_start_o;
  logic [N-1:0] child_done_i = '0;
  logic         busy_o, done_o, err_o;
  logic [2:0]   done_cnt_o;
  int checks = 0;
  int errors = 0;
  tree_node_seq #(.N_CHILD(N), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .child_mask_i (child_mask_i),
    .child_start_o(child_start_o),
    .child_done_i (child_done_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .done_cnt_o   (done_cnt_o)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic m, input logic [N-1:0] mask);
    start_i = 1'b1;
    mode_i = m;
    child_mask_i = mask;
    tick();
    start_i = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_cs", child_start_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cnt", done_cnt_o, 0);
    rst_n = 1'b1;
    tick();
    // parallel, all answer one cycle after the pulse
    go(1'b0, 5'b11111);
    chk("par_cs_T1", child_start_o, 5'b11111);
    chk("par_busy_T1", busy_o, 1);
    tick();
    chk("par_cs_T2", child_start_o, 0);
    child_done_i = 5'b11111;
    tick();
    child_done_i = '0;
    chk("par_done_T3", done_o, 1);
    chk("par_busy_T3", busy_o, 0);
    chk("par_cnt", done_cnt_o, 5);
    chk("par_err", err_o, 0);
    tick();
    chk("par_idle_done", done_o, 0);
    chk("par_idle_cnt", done_cnt_o, 5);
    // sequential 10110 with spurious and duplicate pulses
    go(1'b1, 5'b10110);
    chk("seq_cs1", child_start_o, 5'b00010);
    chk("seq_cnt0", done_cnt_o, 0);
    tick();
    child_done_i = 5'b00001;
    tick();
    child_done_i = 5'b00010;
    chk("seq_spur_cs", child_start_o, 0);
    chk("seq_spur_cnt", done_cnt_o, 0);
    tick();
    child_done_i = '0;
    chk("seq_cs2", child_start_o, 5'b00100);
    chk("seq_cnt1", done_cnt_o, 1);
    tick();
    child_done_i = 5'b00100;
    tick();
    child_done_i = '0;
    chk("seq_cs3", child_start_o, 5'b10000);
    chk("seq_cnt2", done_cnt_o, 2);
    tick();
    child_done_i = 5'b00010;
    tick();
    child_done_i = 5'b10000;
    chk("seq_dup_cnt", done_cnt_o, 2);
    chk("seq_dup_busy", busy_o, 1);
    tick();
    child_done_i = '0;
    chk("seq_done", done_o, 1);
    chk("seq_cnt3", done_cnt_o, 3);
    chk("seq_err", err_o, 0);
    tick();
    // parallel 00011, child 1 never answers -> timeout
    go(1'b0, 5'b00011);
    chk("to_cs", child_start_o, 5'b00011);
    tick();
    child_done_i = 5'b00001;
    start_i = 1'b1;
    tick();
    child_done_i = 5'b00101;
    start_i = 1'b0;
    chk("to_start_ign_cs", child_start_o, 0);
    chk("to_cnt1", done_cnt_o, 1);
    tick();
    child_done_i = '0;
    chk("to_dup_cnt", done_cnt_o, 1);
    for (int i = 0; i < TO - 3; i++) tick();
    chk("to_busy_last", busy_o, 1);
    chk("to_done_last", done_o, 0);
    chk("to_err_last", err_o, 0);
    tick();
    chk("to_done", done_o, 1);
    chk("to_err", err_o, 1);
    chk("to_cnt", done_cnt_o, 1);
    tick();
    chk("to_err_sticky", err_o, 1);
    // completion on the final allowed WAIT cycle beats timeout
    go(1'b0, 5'b00001);
    chk("edge_err_clr", err_o, 0);
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    child_done_i = 5'b00001;
    tick();
    child_done_i = '0;
    chk("edge_done", done_o, 1);
    chk("edge_err", err_o, 0);
    chk("edge_cnt", done_cnt_o, 1);
    tick();
    // empty mask, then start during DONE ignored
    go(1'b0, 5'b00000);
    chk("empty_done_T1", done_o, 1);
    chk("empty_cs", child_start_o, 0);
    chk("empty_cnt", done_cnt_o, 0);
    start_i = 1'b1;
    child_mask_i = 5'b11111;
    tick();
    start_i = 1'b0;
    chk("done_start_ign_busy", busy_o, 0);
    tick();
    chk("done_start_ign_busy2", busy_o, 0);
    chk("done_start_ign_cs", child_start_o, 0);
    // reset mid-WAIT in sequential mode
    go(1'b1, 5'b01100);
    chk("rw_cs1", child_start_o, 5'b00100);
    tick();
    child_done_i = 5'b00100;
    tick();
    child_done_i = '0;
    chk("rw_cs2", child_start_o, 5'b01000);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rw_busy", busy_o, 0);
    chk("rw_cnt", done_cnt_o, 0);
    chk("rw_cs", child_start_o, 0);
    tick();
    chk("rw_no_done", done_o, 0);
    rst_n = 1'b1;
    tick();
    chk("rw_no_done2", done_o, 0);
    go(1'b1, 5'b01100);
    chk("rw_fresh_cs", child_start_o, 5'b00100);
    tick();
    child_done_i = 5'b00100;
    tick();
    child_done_i = '0;
    chk("rw_fresh_cs2", child_start_o, 5'b01000);
    tick();
    child_done_i = 5'b01000;
    tick();
    child_done_i = '0;
    chk("rw_fresh_done", done_o, 1);
    chk("rw_fresh_cnt", done_cnt_o, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
